// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the CPU sequencer: T-state encodings, forced opcodes,
// interrupt bit positions and the phase-generator state type.
package cpu_sequencer_pkg;

  localparam int T_W = 7;

  localparam logic [7:0] BRK_OP = 8'h00;
  localparam logic [7:0] NOP_OP = 8'hEA;

  localparam logic [T_W-1:0] T_ZERO  = 7'b000_0001;
  localparam logic [T_W-1:0] T_ONE   = 7'b000_0010;
  localparam logic [T_W-1:0] T_TWO   = 7'b000_0100;
  localparam logic [T_W-1:0] T_THREE = 7'b000_1000;
  localparam logic [T_W-1:0] T_FOUR  = 7'b001_0000;
  localparam logic [T_W-1:0] T_FIVE  = 7'b010_0000;
  localparam logic [T_W-1:0] T_SIX   = 7'b100_0000;

  localparam int INT_RES = 2;
  localparam int INT_NMI = 1;
  localparam int INT_IRQ = 0;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ONE,
    PH_TWO
  } phase_e;

endpackage

// File: rtl/cpu_sequencer_int_arbiter.sv
// RES/NMI/IRQ arbitration: NMI falling-edge latch, IRQ masking, priority
// encode at the opcode fetch and the activeInt register.
module cpu_sequencer_int_arbiter
  import cpu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic       advance,
  input  logic       fetch,
  input  logic       last_cycle,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       statusI,
  output logic [2:0] active_int,
  output logic       force_brk
);

  logic       nmi_prev;
  logic       nmi_pend;
  logic       nmi_edge;
  logic       irq_pend;
  logic       take_nmi;
  logic [2:0] grant;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    nmi_edge       = sample && nmi_prev && !nmi_n;
    irq_pend       = !irq_n && !statusI;
    grant          = 3'b000;
    grant[INT_NMI] = nmi_pend;
    grant[INT_IRQ] = irq_pend && !nmi_pend;
    take_nmi       = advance && fetch && (active_int == 3'b000) && nmi_pend;
    // A sequence still marked active (the reset sequence) keeps forcing BRK.
    force_brk      = (active_int != 3'b000) || (grant != 3'b000);
  end

  // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_int <= 3'b000;
      active_int[INT_RES] <= 1'b1;
      nmi_prev   <= 1'b1;
      nmi_pend   <= 1'b0;
    end else begin
      if (sample) begin
        nmi_prev <= nmi_n;
      end
      // A fresh edge landing on the edge that takes NMI must stay latched.
      nmi_pend <= (nmi_pend && !take_nmi) || nmi_edge;
      if (advance) begin
        if (fetch) begin
          if (active_int == 3'b000) begin
            active_int <= grant;
          end
        end else if (last_cycle) begin
          active_int <= 3'b000;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU timing sequencer: phi1/phi2 phase pair, one-hot T-state, opcode and
// previous-opcode registers, with interrupt arbitration in a sub-module.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic [7:0]     db_in,
  input  logic           last_cycle,
  input  logic           skip_cycle,
  input  logic           nmi_n,
  input  logic           irq_n,
  input  logic           statusI,
  output logic           phi1,
  output logic           phi2,
  output logic [T_W-1:0] T,
  output logic [7:0]     OP,
  output logic [7:0]     prevOP,
  output logic [2:0]     activeInt,
  output logic           sync,
  output logic           t_overflow
);

  phase_e         phase;
  logic           advance;
  logic           fetch;
  logic           force_brk;
  logic [T_W+1:0] t_shift;
  logic [T_W-1:0] t_next;
  logic           t_wrap;

  assign advance = (phase == PH_TWO) && rdy;
  assign fetch   = (T == T_ONE);

  always_comb begin
    t_shift = {2'b00, T} << (skip_cycle ? 2'd2 : 2'd1);
    t_next  = t_shift[T_W-1:0];
    t_wrap  = 1'b0;
    if (last_cycle) begin
      t_next = T_ONE;
    end else if (fetch) begin
      t_next = T_TWO;
    end else if (t_shift[T_W+1:T_W] != 2'b00) begin
      t_next = T_ONE;
      t_wrap = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_IDLE;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      T          <= T_ONE;
      OP         <= BRK_OP;
      prevOP     <= NOP_OP;
      sync       <= 1'b1;
      t_overflow <= 1'b0;
    end else begin
      case (phase)
        PH_ONE: begin
          phase <= PH_TWO;
          phi1  <= 1'b0;
          phi2  <= 1'b1;
        end
        default: begin
          phase <= PH_ONE;
          phi1  <= 1'b1;
          phi2  <= 1'b0;
        end
      endcase
      if (advance) begin
        T    <= t_next;
        sync <= (t_next == T_ONE);
        if (t_wrap) begin
          t_overflow <= 1'b1;
        end
        if (fetch) begin
          prevOP <= OP;
          OP     <= force_brk ? BRK_OP : db_in;
        end
      end
    end
  end

  cpu_sequencer_int_arbiter u_int_arbiter (
    .clk        (clk),
    .rst        (rst),
    .sample     (phase == PH_TWO),
    .advance    (advance),
    .fetch      (fetch),
    .last_cycle (last_cycle),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .statusI    (statusI),
    .active_int (activeInt),
    .force_brk  (force_brk)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios followed by random stimulus,
// every clock compared against a cycle-level behavioural model.
module tb_cpu_sequencer;

  localparam logic [7:0] TS1 = 8'h02;
  localparam logic [7:0] TS2 = 8'h04;
  localparam logic [7:0] TS3 = 8'h08;
  localparam logic [7:0] TS4 = 8'h10;
  localparam logic [7:0] TS5 = 8'h20;

  logic       clk = 1'b0;
  logic       rst, rdy, last_cycle, skip_cycle, nmi_n, irq_n, statusI;
  logic [7:0] db_in;
  logic       phi1, phi2, sync, t_overflow;
  logic [6:0] T;
  logic [7:0] OP, prevOP;
  logic [2:0] activeInt;

  int errors = 0;
  int checks = 0;

  // Model state: phase 0 = after reset, 1 = phi1 half, 2 = phi2 half; m_t = T-state number.
  int         m_ph, m_t;
  logic [7:0] m_op, m_prev;
  logic [2:0] m_act;
  bit         m_ovf, m_nmi_prev, m_nmi_pend;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .db_in      (db_in),
    .last_cycle (last_cycle),
    .skip_cycle (skip_cycle),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .statusI    (statusI),
    .phi1       (phi1),
    .phi2       (phi2),
    .T          (T),
    .OP         (OP),
    .prevOP     (prevOP),
    .activeInt  (activeInt),
    .sync       (sync),
    .t_overflow (t_overflow)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit new_edge;
    bit taken_nmi;
    if (rst) begin
      m_ph = 0; m_t = 1; m_op = 8'h00; m_prev = 8'hEA; m_act = 3'b100;
      m_ovf = 0; m_nmi_prev = 1; m_nmi_pend = 0;
      return;
    end
    new_edge  = 0;
    taken_nmi = 0;
    if (m_ph == 2) begin
      new_edge   = m_nmi_prev && !nmi_n;
      m_nmi_prev = nmi_n;
    end
    if (m_ph == 2 && rdy) begin
      if (m_t == 1) begin
        if (m_act == 3'b000) begin
          if (m_nmi_pend) begin
            m_act = 3'b010;
            taken_nmi = 1;
          end else if (!irq_n && !statusI) begin
            m_act = 3'b001;
          end
        end
        m_prev = m_op;
        m_op   = (m_act != 3'b000) ? 8'h00 : db_in;
      end else if (last_cycle) begin
        m_act = 3'b000;
      end
      if (last_cycle) m_t = 1;
      else if (m_t == 1) m_t = 2;
      else begin
        m_t += skip_cycle ? 2 : 1;
        if (m_t > 6) begin
          m_t = 1;
          m_ovf = 1;
        end
      end
    end
    m_nmi_pend = (m_nmi_pend && !taken_nmi) || new_edge;
    m_ph = (m_ph == 1) ? 2 : 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("phi1", 8'(phi1), 8'(m_ph == 1));
    check("phi2", 8'(phi2), 8'(m_ph == 2));
    check("T", 8'(T), 8'(1 << m_t));
    check("OP", OP, m_op);
    check("prevOP", prevOP, m_prev);
    check("activeInt", 8'(activeInt), 8'(m_act));
    check("sync", 8'(sync), 8'(m_t == 1));
    check("t_overflow", 8'(t_overflow), 8'(m_ovf));
  endtask

  // Clocks until the model has just taken an advance edge.
  task automatic next_adv();
    for (int i = 0; i < 4; i++) begin
      bit was_adv;
      was_adv = (m_ph == 2) && rdy;
      step();
      if (was_adv) return;
    end
  endtask

  initial begin
    rst = 1; rdy = 1; db_in = 8'hA9; last_cycle = 0; skip_cycle = 0;
    nmi_n = 1; irq_n = 1; statusI = 1;
    step();
    check("rst_T", 8'(T), TS1);
    check("rst_OP", OP, 8'h00);
    check("rst_prevOP", prevOP, 8'hEA);
    check("rst_act", 8'(activeInt), 8'h04);
    check("rst_phases", {6'b0, phi1, phi2}, 8'h00);
    rst = 0;

    // Reset BRK sequence then fetch A9.
    step();
    check("first_phi1", {6'b0, phi1, phi2}, 8'h02);
    step();
    check("then_phi2", {6'b0, phi1, phi2}, 8'h01);
    step();
    check("brk_fetch_op", OP, 8'h00);
    check("brk_fetch_act", 8'(activeInt), 8'h04);
    last_cycle = 1;
    next_adv();
    check("brk_done_act", 8'(activeInt), 8'h00);
    last_cycle = 0;
    next_adv();
    check("a9_op", OP, 8'hA9);
    check("a9_prev", prevOP, 8'h00);

    // ADC 69 then fetch EA.
    db_in = 8'h69; last_cycle = 1;
    next_adv();
    check("adc_t_one", 8'(T), TS1);
    last_cycle = 0;
    next_adv();
    check("adc_t_two", 8'(T), TS2);
    last_cycle = 1;
    next_adv();
    check("adc_end_t_one", 8'(T), TS1);
    db_in = 8'hEA; last_cycle = 0;
    next_adv();
    check("ea_t_two", 8'(T), TS2);
    check("ea_prev", prevOP, 8'h69);
    check("ea_op", OP, 8'hEA);

    // Skip to Tfour, then run past Tsix into overflow.
    skip_cycle = 1;
    next_adv();
    check("skip_t_four", 8'(T), TS4);
    skip_cycle = 0;
    next_adv();
    next_adv();
    next_adv();
    check("wrap_t_one", 8'(T), TS1);
    check("wrap_ovf", 8'(t_overflow), 8'h01);
    next_adv();
    next_adv();
    check("ovf_sticky", 8'(t_overflow), 8'h01);
    check("t_three", 8'(T), TS3);

    // rdy low in Tthree.
    rdy = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("hold_T", 8'(T), TS3);
    end
    rdy = 1;
    next_adv();
    check("resume_t_four", 8'(T), TS4);

    // IRQ masked, then unmasked, then NMI beating IRQ.
    last_cycle = 1;
    next_adv();
    last_cycle = 0; irq_n = 0; statusI = 1;
    next_adv();
    check("irq_masked_act", 8'(activeInt), 8'h00);
    check("irq_masked_op", OP, 8'hEA);
    last_cycle = 1;
    next_adv();
    last_cycle = 0; statusI = 0;
    next_adv();
    check("irq_op", OP, 8'h00);
    check("irq_act", 8'(activeInt), 8'h01);
    nmi_n = 0; last_cycle = 1;
    next_adv();
    check("irq_done_act", 8'(activeInt), 8'h00);
    last_cycle = 0;
    next_adv();
    check("nmi_op", OP, 8'h00);
    check("nmi_act", 8'(activeInt), 8'h02);
    nmi_n = 1; irq_n = 1; statusI = 1; last_cycle = 1;
    next_adv();
    last_cycle = 0;
    next_adv();
    next_adv();
    next_adv();
    next_adv();
    check("pre_rst_t_five", 8'(T), TS5);
    step();
    rst = 1;
    step();
    check("mid_rst_T", 8'(T), TS1);
    check("mid_rst_act", 8'(activeInt), 8'h04);
    check("mid_rst_op", OP, 8'h00);
    check("mid_rst_prev", prevOP, 8'hEA);
    check("mid_rst_ovf", 8'(t_overflow), 8'h00);
    rst = 0;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rdy        = ($urandom_range(0, 4) != 0);
      db_in      = 8'($urandom);
      last_cycle = (m_t != 1) && ($urandom_range(0, 2) == 0);
      skip_cycle = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) nmi_n = ~nmi_n;
      irq_n      = ($urandom_range(0, 3) != 0);
      statusI    = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
